accel_host_port: RTL and testbench
==================================

Name: accel_host_port

Overview:
Host-side companion to the matrix accelerator. It owns the input operand memory, which it serves to the accelerator's read port, and the result memory, which it fills from the accelerator's write port. It also sequences one job: stream-load operands, pulse `comp_enb`, wait for `done`, then stream-drain results to the host over a valid/ready interface.

Parameters:
IN_AW, 16, input memory address width (A words at 0x0000-0x7FFF, B words at 0x8000-0xFFFF)
RES_AW, 15, result memory address width
DRAIN_LEN, 32768, number of result words drained per job (<= 2^RES_AW)

Ports:
clk  input  1  system clock, all logic on rising edge
rstb  input  1  synchronous active-low reset
load_valid  input  1  host load beat valid
load_ready  output  1  host load beat accepted when valid&ready
load_data  input  64  operand word, written to in_mem[load_ptr]
start  input  1  single-cycle request to run the job
drain_valid  output  1  result beat valid
drain_ready  input  1  host accepts result beat
drain_data  output  64  result word
drain_last  output  1  marks beat DRAIN_LEN-1
phase  output  2  0=IDLE 1=RESET 2=RUN 3=DRAIN
wr_count  output  17  accelerator write cycles this job, saturating
err  output  1  sticky: out-of-range or out-of-phase result write
comp_enb  output  1  accelerator compute enable (high holds accelerator in reset state)
mem_addr  input  16  accelerator read address
mem_read_enb  input  1  active-low read enable
mem_data  output  64  read data
res_addr  input  16  accelerator result address
res_data  input  64  result word
mem_write_enb  input  1  active-low write enable
done  input  1  accelerator job complete

Behaviour:
- Reset (rstb=0 at edge):
  - phase=IDLE, comp_enb=1, load_ready=0, drain_valid=0, drain_data=0, drain_last=0.
  - load_ptr=0, drain_ptr=0, wr_count=0, err=0.
  - Memory contents are retained. Reset mid-job aborts immediately with no partial drain.
- mem_data is combinational: in_mem[mem_addr[IN_AW-1:0]] when mem_read_enb=0, else 64'h0, in every phase.
  - The accelerator drives the address at edge k and samples the data at edge k+1, so the read path has zero added latency.
- IDLE:
  - load_ready=1. Each valid&ready beat writes in_mem[load_ptr] and increments load_ptr, wrapping at 2^IN_AW.
  - On start=1: go to RESET next cycle. A load beat accepted in the same cycle is still written.
  - On start, load_ptr, wr_count and err are cleared.
- RESET: comp_enb=1, load_ready=0, held for exactly 2 cycles, then RUN.
- RUN:
  - comp_enb=0 from the first RUN cycle.
  - Each cycle with mem_write_enb=0 writes res_mem[res_addr[RES_AW-1:0]] <= res_data and increments wr_count (saturating at 2^17-1).
  - If res_addr >= 2^RES_AW, err is set and the write is still performed on the truncated address.
  - On done=1: comp_enb returns to 1 next cycle and phase goes to DRAIN. A write in the same cycle as done is committed.
  - start is ignored.
- DRAIN:
  - Reads res_mem[0..DRAIN_LEN-1] in order, with registered sync-read plus one skid entry.
  - drain_valid rises no later than 2 cycles after DRAIN entry.
  - With drain_ready held high, one beat per cycle with no bubbles.
  - drain_data and drain_last are stable while drain_valid & !drain_ready.
  - After the handshake of beat DRAIN_LEN-1 (drain_last=1): drain_valid=0, phase=IDLE.
  - start is ignored.
- mem_write_enb=0 outside RUN: no memory write, err set.
- load_valid outside IDLE: not accepted (load_ready=0), data dropped by protocol.

Test Plan:
- Reset (IN_AW=6, RES_AW=4, DRAIN_LEN=16): hold rstb=0 for 3 cycles -> comp_enb=1, phase=0, load_ready=0, drain_valid=0, err=0, wr_count=0.
- Load/read: load beats 64'h1000+i for i=0..63, then drive mem_read_enb=0, mem_addr=5 -> mem_data=64'h1005 in the same cycle. mem_read_enb=1 -> mem_data=0.
- Start sequence: pulse start -> phase=1 for 2 cycles with comp_enb=1, then phase=2 with comp_enb=0. A load beat coincident with start is written at load_ptr.
- Writes/done: in RUN, write res_addr=i, res_data=64'hA0+i for i=0..15, with done=1 on the last write cycle -> wr_count=16, comp_enb=1 next cycle, phase=3, err=0.
- Drain backpressure: drain_ready toggles 1,0,1,0... -> beats 64'hA0..64'hAF in order with no loss or duplication, data held while stalled, drain_last only on 64'hAF, then phase=0.
- Error/abort: res_addr=16'h0010 write in RUN -> err=1, res_mem[0] overwritten. mem_write_enb=0 in IDLE -> err=1. rstb=0 mid-DRAIN -> drain_valid=0, phase=0 next cycle, in_mem retained (mem_data at address 5 still 64'h1005).

Source files
------------

// File: rtl/accel_host_port.sv
`default_nettype none
// ---------------------------------------------------------------------------
// accel_host_port : operand/result memories and job sequencer for the matrix accelerator
// Revision: 1.0
// ---------------------------------------------------------------------------
module accel_host_port #(
  parameter int IN_AW     = 16,
  parameter int RES_AW    = 15,
  parameter int DRAIN_LEN = 32768
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [63:0] load_data,
  input  logic        start,
  output logic        drain_valid,
  input  logic        drain_ready,
  output logic [63:0] drain_data,
  output logic        drain_last,
  output logic [1:0]  phase,
  output logic [16:0] wr_count,
  output logic        err,
  output logic        comp_enb,
  input  logic [15:0] mem_addr,
  input  logic        mem_read_enb,
  output logic [63:0] mem_data,
  input  logic [15:0] res_addr,
  input  logic [63:0] res_data,
  input  logic        mem_write_enb,
  input  logic        done
);

  localparam int             PW             = RES_AW + 1;
  localparam logic [PW-1:0]  DRAIN_END      = PW'(DRAIN_LEN);
  localparam logic [PW-1:0]  DRAIN_LAST_IDX = PW'(DRAIN_LEN - 1);
  localparam logic [16:0]    RES_LIMIT      = 17'(2 ** RES_AW);
  localparam logic [16:0]    WR_MAX         = '1;

  typedef enum logic [1:0] {
    PH_IDLE  = 2'd0,
    PH_RESET = 2'd1,
    PH_RUN   = 2'd2,
    PH_DRAIN = 2'd3
  } phase_e;

  logic [63:0] in_mem  [2**IN_AW];
  logic [63:0] res_mem [2**RES_AW];

  phase_e            phase_q, phase_d;
  logic              rst_cnt_q, rst_cnt_d;
  logic              comp_enb_q, comp_enb_d;
  logic              load_ready_q, load_ready_d;
  logic [IN_AW-1:0]  load_ptr_q, load_ptr_d;
  logic [16:0]       wr_count_q, wr_count_d;
  logic              err_q, err_d;
  logic [PW-1:0]     drain_ptr_q, drain_ptr_d;
  logic              rd_pend_q, rd_pend_d;
  logic              rd_last_q, rd_last_d;
  logic [63:0]       rd_data_q;
  logic              out_valid_q, out_valid_d;
  logic [63:0]       out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic              sk_valid_q, sk_valid_d;
  logic [63:0]       sk_data_q, sk_data_d;
  logic              sk_last_q, sk_last_d;

  logic       load_fire;
  logic       res_wr;
  logic       res_oob;
  logic       pop;
  logic [1:0] occ;
  logic       rd_issue;

  assign load_fire = load_valid & load_ready_q;
  assign res_wr    = (phase_q == PH_RUN) & ~mem_write_enb;
  assign res_oob   = ({1'b0, res_addr} >= RES_LIMIT);
  assign pop       = (phase_q == PH_DRAIN) & out_valid_q & drain_ready;
  // Entries held or in flight after this cycle's pop; at most two may exist.
  assign occ       = 2'(out_valid_q) + 2'(sk_valid_q) + 2'(rd_pend_q) - 2'(pop);
  assign rd_issue  = (phase_q == PH_DRAIN) && (drain_ptr_q < DRAIN_END) && (occ < 2'd2);

  assign mem_data    = mem_read_enb ? 64'h0 : in_mem[mem_addr[IN_AW-1:0]];
  assign load_ready  = load_ready_q;
  assign drain_valid = out_valid_q;
  assign drain_data  = out_data_q;
  assign drain_last  = out_last_q;
  assign phase       = phase_q;
  assign wr_count    = wr_count_q;
  assign err         = err_q;
  assign comp_enb    = comp_enb_q;

  always_ff @(posedge clk) begin
    if (load_fire) begin
      in_mem[load_ptr_q] <= load_data;
    end
    if (res_wr) begin
      res_mem[res_addr[RES_AW-1:0]] <= res_data;
    end
    if (rd_issue) begin
      rd_data_q <= res_mem[drain_ptr_q[RES_AW-1:0]];
    end
  end

  always_comb begin
    phase_d     = phase_q;
    rst_cnt_d   = rst_cnt_q;
    load_ptr_d  = load_ptr_q;
    wr_count_d  = wr_count_q;
    err_d       = err_q;
    drain_ptr_d = drain_ptr_q;
    rd_pend_d   = 1'b0;
    rd_last_d   = rd_last_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    sk_valid_d  = sk_valid_q;
    sk_data_d   = sk_data_q;
    sk_last_d   = sk_last_q;

    case (phase_q)
      PH_IDLE: begin
        if (load_fire) begin
          load_ptr_d = load_ptr_q + IN_AW'(1);
        end
        if (start) begin
          phase_d    = PH_RESET;
          rst_cnt_d  = 1'b0;
          load_ptr_d = '0;
          wr_count_d = '0;
          err_d      = 1'b0;
        end
      end
      PH_RESET: begin
        if (rst_cnt_q) begin
          phase_d = PH_RUN;
        end else begin
          rst_cnt_d = 1'b1;
        end
      end
      PH_RUN: begin
        if (res_wr) begin
          if (wr_count_q != WR_MAX) begin
            wr_count_d = wr_count_q + 17'd1;
          end
          if (res_oob) begin
            err_d = 1'b1;
          end
        end
        if (done) begin
          phase_d     = PH_DRAIN;
          drain_ptr_d = '0;
          out_valid_d = 1'b0;
          sk_valid_d  = 1'b0;
        end
      end
      PH_DRAIN: begin
        if (rd_issue) begin
          drain_ptr_d = drain_ptr_q + PW'(1);
          rd_pend_d   = 1'b1;
          rd_last_d   = (drain_ptr_q == DRAIN_LAST_IDX);
        end
        // Output slot is refilled from the skid first, so beat order is kept.
        if (!out_valid_q || pop) begin
          if (sk_valid_q) begin
            out_valid_d = 1'b1;
            out_data_d  = sk_data_q;
            out_last_d  = sk_last_q;
            sk_valid_d  = rd_pend_q;
            sk_data_d   = rd_data_q;
            sk_last_d   = rd_last_q;
          end else if (rd_pend_q) begin
            out_valid_d = 1'b1;
            out_data_d  = rd_data_q;
            out_last_d  = rd_last_q;
          end else begin
            out_valid_d = 1'b0;
          end
        end else if (rd_pend_q) begin
          sk_valid_d = 1'b1;
          sk_data_d  = rd_data_q;
          sk_last_d  = rd_last_q;
        end
        if (pop && out_last_q) begin
          phase_d     = PH_IDLE;
          out_valid_d = 1'b0;
          sk_valid_d  = 1'b0;
        end
      end
      default: phase_d = PH_IDLE;
    endcase

    if (!mem_write_enb && (phase_q != PH_RUN)) begin
      err_d = 1'b1;
    end

    comp_enb_d   = (phase_d != PH_RUN);
    load_ready_d = (phase_d == PH_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      phase_q      <= PH_IDLE;
      rst_cnt_q    <= 1'b0;
      comp_enb_q   <= 1'b1;
      load_ready_q <= 1'b0;
      load_ptr_q   <= '0;
      wr_count_q   <= '0;
      err_q        <= 1'b0;
      drain_ptr_q  <= '0;
      rd_pend_q    <= 1'b0;
      rd_last_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      sk_valid_q   <= 1'b0;
      sk_data_q    <= '0;
      sk_last_q    <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      rst_cnt_q    <= rst_cnt_d;
      comp_enb_q   <= comp_enb_d;
      load_ready_q <= load_ready_d;
      load_ptr_q   <= load_ptr_d;
      wr_count_q   <= wr_count_d;
      err_q        <= err_d;
      drain_ptr_q  <= drain_ptr_d;
      rd_pend_q    <= rd_pend_d;
      rd_last_q    <= rd_last_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      sk_valid_q   <= sk_valid_d;
      sk_data_q    <= sk_data_d;
      sk_last_q    <= sk_last_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_accel_host_port.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_accel_host_port : directed self-checking bench for accel_host_port
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_accel_host_port;

  logic        clk = 1'b0;
  logic        rstb;
  logic        load_valid;
  logic        load_ready;
  logic [63:0] load_data;
  logic        start;
  logic        drain_valid;
  logic        drain_ready;
  logic [63:0] drain_data;
  logic        drain_last;
  logic [1:0]  phase;
  logic [16:0] wr_count;
  logic        err;
  logic        comp_enb;
  logic [15:0] mem_addr;
  logic        mem_read_enb;
  logic [63:0] mem_data;
  logic [15:0] res_addr;
  logic [63:0] res_data;
  logic        mem_write_enb;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  accel_host_port #(.IN_AW(6), .RES_AW(4), .DRAIN_LEN(16)) dut (
    .clk(clk), .rstb(rstb),
    .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
    .start(start),
    .drain_valid(drain_valid), .drain_ready(drain_ready), .drain_data(drain_data),
    .drain_last(drain_last),
    .phase(phase), .wr_count(wr_count), .err(err), .comp_enb(comp_enb),
    .mem_addr(mem_addr), .mem_read_enb(mem_read_enb), .mem_data(mem_data),
    .res_addr(res_addr), .res_data(res_data), .mem_write_enb(mem_write_enb),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [63:0] held;
    logic        stalled;
    int          idx;
    logic [63:0] exp2 [4];

    rstb = 1'b0; load_valid = 1'b0; load_data = '0; start = 1'b0;
    drain_ready = 1'b0; mem_addr = '0; mem_read_enb = 1'b1;
    res_addr = '0; res_data = '0; mem_write_enb = 1'b1; done = 1'b0;

    repeat (3) tick();
    check("rst_comp_enb", comp_enb, 1);
    check("rst_phase", phase, 0);
    check("rst_load_ready", load_ready, 0);
    check("rst_drain_valid", drain_valid, 0);
    check("rst_err", err, 0);
    check("rst_wr_count", wr_count, 0);

    rstb = 1'b1;
    tick();
    check("idle_load_ready", load_ready, 1);

    for (int i = 0; i < 64; i++) begin
      load_valid = 1'b1;
      load_data  = 64'h1000 + 64'(i);
      tick();
    end
    load_valid = 1'b0;

    mem_read_enb = 1'b0; mem_addr = 16'd5; #1;
    check("rd_addr5", mem_data, 64'h1005);
    mem_addr = 16'd63; #1;
    check("rd_addr63", mem_data, 64'h103F);
    mem_read_enb = 1'b1; #1;
    check("rd_disabled", mem_data, 64'h0);

    // load_ptr has wrapped to 0; the beat coincident with start lands there
    start = 1'b1; load_valid = 1'b1; load_data = 64'hBEEF;
    tick();
    start = 1'b0; load_valid = 1'b1; load_data = 64'h5555;
    check("start_phase1a", phase, 1);
    check("start_comp_enb_a", comp_enb, 1);
    check("start_load_ready", load_ready, 0);
    tick();
    load_valid = 1'b0;
    check("start_phase1b", phase, 1);
    check("start_comp_enb_b", comp_enb, 1);
    tick();
    check("run_phase", phase, 2);
    check("run_comp_enb", comp_enb, 0);
    mem_read_enb = 1'b0; mem_addr = 16'd0; #1;
    check("rd_start_beat", mem_data, 64'hBEEF);
    mem_addr = 16'd1; #1;
    check("rd_addr1", mem_data, 64'h1001);
    mem_read_enb = 1'b1;

    for (int i = 0; i < 16; i++) begin
      mem_write_enb = 1'b0;
      res_addr = 16'(i);
      res_data = 64'hA0 + 64'(i);
      done = (i == 15);
      tick();
    end
    mem_write_enb = 1'b1; done = 1'b0;
    check("done_phase", phase, 3);
    check("done_comp_enb", comp_enb, 1);
    check("done_wr_count", wr_count, 16);
    check("done_err", err, 0);

    idx = 0; stalled = 1'b0; held = '0;
    for (int c = 0; c < 200 && idx < 16; c++) begin
      drain_ready = (c % 2 == 0);
      if (stalled) begin
        check("drain_hold_valid", drain_valid, 1);
        check("drain_hold_data", drain_data, held);
      end
      stalled = 1'b0;
      if (drain_valid && drain_ready) begin
        check("drain_data", drain_data, 64'hA0 + 64'(idx));
        check("drain_last", drain_last, (idx == 15));
        idx++;
      end else if (drain_valid) begin
        stalled = 1'b1;
        held    = drain_data;
      end
      tick();
    end
    drain_ready = 1'b0;
    check("drain_count", idx, 16);
    check("drain_end_phase", phase, 0);
    check("drain_end_valid", drain_valid, 0);

    mem_write_enb = 1'b0; res_addr = 16'd3; res_data = 64'hFFFF;
    tick();
    mem_write_enb = 1'b1;
    check("idle_wr_err", err, 1);
    check("idle_wr_count", wr_count, 16);

    start = 1'b1;
    tick();
    start = 1'b0;
    check("job2_err_clear", err, 0);
    check("job2_wr_clear", wr_count, 0);
    tick();
    tick();
    check("job2_run", phase, 2);
    mem_write_enb = 1'b0; res_addr = 16'h0010; res_data = 64'hDEAD;
    tick();
    mem_write_enb = 1'b1;
    check("oob_err", err, 1);
    check("oob_wr_count", wr_count, 1);
    done = 1'b1;
    tick();
    done = 1'b0;
    drain_ready = 1'b1;
    check("job2_drain", phase, 3);

    for (int c = 0; c < 5 && !drain_valid; c++) tick();
    exp2[0] = 64'hDEAD; exp2[1] = 64'hA1; exp2[2] = 64'hA2; exp2[3] = 64'hA3;
    for (int k = 0; k < 4; k++) begin
      check("job2_valid", drain_valid, 1);
      check("job2_data", drain_data, exp2[k]);
      tick();
    end

    rstb = 1'b0;
    tick();
    rstb = 1'b1;
    check("abort_valid", drain_valid, 0);
    check("abort_phase", phase, 0);
    check("abort_comp_enb", comp_enb, 1);
    mem_read_enb = 1'b0; mem_addr = 16'd5; #1;
    check("abort_in_mem5", mem_data, 64'h1005);
    mem_addr = 16'd0; #1;
    check("abort_in_mem0", mem_data, 64'hBEEF);
    mem_read_enb = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
